cms_axis_receiver: RTL and testbench

AXI-Stream slave that terminates the trace stream produced by continuous_monitoring_system (96-bit {pc, instr} items, tlast every tlast_interval items). It buffers items in a small first-word-fall-through (FWFT) FIFO, unpacks them into pc/instr fields and checks tlast framing against tlast_interval. It keeps item and frame counters for the host and feeds a downstream consumer over a valid/ready port. It sits in the host-side shell, used for loopback verification and on-chip trace consumers.

---
 rtl/cms_axis_receiver.sv | 165 ++++++++++++++++
 tb/tb_cms_axis_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cms_axis_receiver.sv
// cms_axis_receiver: AXI-Stream sink for the continuous_monitoring_system trace.
// Incoming {pc, instr} beats go into a small FWFT FIFO with registered head outputs.
// Each accepted beat is checked against the expected tlast spacing. Item, frame
// and drop counters are kept for the host.
// Optional build macro CMS_RX_DROP_ON_FULL_EN: tready follows en only, and beats
// that arrive while the FIFO is full are discarded and counted in drop_count.
module cms_axis_receiver #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned AXI_DATA_WIDTH = XLEN + 32,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_last,
    output logic [CNT_WIDTH-1:0]      item_count,
    output logic [CNT_WIDTH-1:0]      frame_count,
    output logic                      framing_error,
    input  logic                      clear_errors,
    output logic [CNT_WIDTH-1:0]      drop_count
);

    localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned ENTRY_W = AXI_DATA_WIDTH + 1;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_n, rd_ptr_n;
    logic               full, full_n, empty_n;
    logic               accept, push, pop;
    logic [ENTRY_W-1:0] head_n;
    logic [31:0]        beat_idx, beat_idx_n, beat_plus;
    logic               frame_err_set;

    // Handshake decode and pointer arithmetic for this cycle
    always_comb begin
        full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        accept   = S_AXIS_tvalid && S_AXIS_tready;
        push     = accept && !full;
        pop      = out_valid && out_ready;
        wr_ptr_n = wr_ptr + (push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_n = rd_ptr + (pop ? PTR_W'(1) : PTR_W'(0));
        full_n   = (wr_ptr_n[PTR_W-1] != rd_ptr_n[PTR_W-1]) &&
                   (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0]);
        empty_n  = (wr_ptr_n == rd_ptr_n);
        // When the next head slot is the one being written now, bypass the array
        if (rd_ptr_n == wr_ptr) begin
            head_n = {S_AXIS_tlast, S_AXIS_tdata};
        end else begin
            head_n = mem[rd_ptr_n[ADDR_W-1:0]];
        end
    end

    // Beat index tracking and framing violation detection
    always_comb begin
        beat_plus     = beat_idx + 32'd1;
        beat_idx_n    = beat_idx;
        frame_err_set = 1'b0;
        if (accept) begin
            if (tlast_interval != 32'd0 && S_AXIS_tlast && beat_plus != tlast_interval) begin
                frame_err_set = 1'b1;
                beat_idx_n    = 32'd0;
            end else if (tlast_interval != 32'd0 && !S_AXIS_tlast && beat_plus == tlast_interval) begin
                frame_err_set = 1'b1;
                beat_idx_n    = 32'd0;
            end else if (S_AXIS_tlast) begin
                beat_idx_n = 32'd0;
            end else begin
                beat_idx_n = beat_plus;
            end
        end
    end

    // FIFO storage array; contents need no reset because pointers gate them
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {S_AXIS_tlast, S_AXIS_tdata};
        end
    end

    // Pointers, registered head outputs and tready from next-state occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= '0;
            out_last      <= 1'b0;
            S_AXIS_tready <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            out_valid <= !empty_n;
            if (!empty_n) begin
                out_last  <= head_n[ENTRY_W-1];
                out_pc    <= head_n[AXI_DATA_WIDTH-1:32];
                out_instr <= head_n[31:0];
            end
`ifdef CMS_RX_DROP_ON_FULL_EN
            S_AXIS_tready <= en;
`else
            S_AXIS_tready <= en && !full_n;
`endif
        end
    end

    // Framing state, sticky error and saturating counters; clear beats accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx      <= '0;
            framing_error <= 1'b0;
            item_count    <= '0;
            frame_count   <= '0;
        end else begin
            beat_idx <= beat_idx_n;
            if (clear_errors) begin
                framing_error <= 1'b0;
                item_count    <= '0;
                frame_count   <= '0;
            end else begin
                if (frame_err_set) begin
                    framing_error <= 1'b1;
                end
                if (accept && item_count != '1) begin
                    item_count <= item_count + CNT_WIDTH'(1);
                end
                if (accept && S_AXIS_tlast && frame_count != '1) begin
                    frame_count <= frame_count + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef CMS_RX_DROP_ON_FULL_EN
    logic drop;
    assign drop = accept && full;

    // Count beats discarded because the FIFO had no room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (clear_errors) begin
            drop_count <= '0;
        end else if (drop && drop_count != '1) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_cms_axis_receiver.sv
// Randomized self-checking bench for cms_axis_receiver against a queue-based model.
module tb_cms_axis_receiver;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DW    = XLEN + 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 32;
`ifdef CMS_RX_DROP_ON_FULL_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            S_AXIS_tvalid;
    logic            S_AXIS_tready;
    logic [DW-1:0]   S_AXIS_tdata;
    logic            S_AXIS_tlast;
    logic [31:0]     tlast_interval;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_last;
    logic [CW-1:0]   item_count;
    logic [CW-1:0]   frame_count;
    logic            framing_error;
    logic            clear_errors;
    logic [CW-1:0]   drop_count;

    cms_axis_receiver #(
        .XLEN(XLEN), .AXI_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
        .tlast_interval(tlast_interval),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_last(out_last),
        .item_count(item_count), .frame_count(frame_count),
        .framing_error(framing_error), .clear_errors(clear_errors),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW:0]  q[$];
    int unsigned  m_items, m_frames, m_drops, m_beat;
    bit           m_ferr, m_tready;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        logic [DW:0] head;
        chk("tready", 64'(S_AXIS_tready), 64'(m_tready));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            head = q[0];
            chk("out_pc", out_pc, head[DW-1:32]);
            chk("out_instr", 64'(out_instr), 64'(head[31:0]));
            chk("out_last", 64'(out_last), 64'(head[DW]));
        end
        chk("item_count", 64'(item_count), 64'(m_items));
        chk("frame_count", 64'(frame_count), 64'(m_frames));
        chk("framing_error", 64'(framing_error), 64'(m_ferr));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    // One clock: drive inputs at negedge, advance the model across the posedge, check
    task automatic cycle(input bit tv, input logic [63:0] pc, input logic [31:0] ins,
                         input bit lst, input bit ordy, output bit acc);
        bit pop, full_before, at_end;
        S_AXIS_tvalid = tv;
        S_AXIS_tdata  = {pc, ins};
        S_AXIS_tlast  = lst;
        out_ready     = ordy;
        acc         = tv && m_tready;
        pop         = ordy && (q.size() != 0);
        full_before = (q.size() >= DEPTH);
        @(posedge clk);
        @(negedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            at_end = (tlast_interval != 0) && (m_beat + 1 == tlast_interval);
            if (tlast_interval != 0 && lst != at_end) m_ferr = 1'b1;
            m_beat = (lst || at_end) ? 0 : m_beat + 1;
            if (full_before) m_drops++;
            else q.push_back({lst, pc, ins});
            m_items++;
            if (lst) m_frames++;
        end
        if (clear_errors) begin
            m_ferr = 1'b0; m_items = 0; m_frames = 0; m_drops = 0;
        end
        m_tready = en && (DROP_MODE || q.size() < DEPTH);
        check_state();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    // Hold one beat until it is accepted, bounded
    task automatic send(input logic [63:0] pc, input logic [31:0] ins, input bit lst, input bit ordy);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 50) begin
            cycle(1'b1, pc, ins, lst, ordy, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_tready", 64'(S_AXIS_tready), 64'd0);
        chk("rst_items", 64'(item_count), 64'd0);
        chk("rst_frames", 64'(frame_count), 64'd0);
        chk("rst_ferr", 64'(framing_error), 64'd0);
        q.delete();
        m_items = 0; m_frames = 0; m_drops = 0; m_beat = 0;
        m_ferr = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_state();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        rst = 1'b1; en = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; S_AXIS_tlast = 1'b0;
        tlast_interval = 32'd0; out_ready = 1'b0; clear_errors = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        en = 1'b1;

        // Two well-formed frames of 5
        tlast_interval = 32'd5;
        idle(1);
        for (int b = 0; b < 10; b++) send({$urandom, $urandom}, $urandom, (b % 5) == 4, 1'b1);
        idle(3);
        chk("t1_items", 64'(item_count), 64'd10);
        chk("t1_frames", 64'(frame_count), 64'd2);
        chk("t1_ferr", 64'(framing_error), 64'd0);

        // Early tlast, then a correct frame, then clear
        clear_errors = 1'b1; idle(1); clear_errors = 1'b0;
        tlast_interval = 32'd4;
        for (int b = 0; b < 3; b++) send({$urandom, $urandom}, $urandom, b == 2, 1'b1);
        chk("t2_ferr_set", 64'(framing_error), 64'd1);
        for (int b = 0; b < 4; b++) send({$urandom, $urandom}, $urandom, b == 3, 1'b1);
        idle(2);
        chk("t2_frames", 64'(frame_count), 64'd2);
        chk("t2_ferr_sticky", 64'(framing_error), 64'd1);
        clear_errors = 1'b1; idle(1); clear_errors = 1'b0;
        chk("t2_ferr_clr", 64'(framing_error), 64'd0);
        chk("t2_items_clr", 64'(item_count), 64'd0);

        // Fill with no consumer, then drain in order
        tlast_interval = 32'd0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 64'(8 + 4 * n), 32'(n), 1'b0, 1'b0, acc);
            if (acc) n++;
        end
`ifndef CMS_RX_DROP_ON_FULL_EN
        chk("t3_accepts", 64'(n), 64'(DEPTH));
        chk("t3_tready_low", 64'(S_AXIS_tready), 64'd0);
        chk("t3_head_pc", out_pc, 64'd8);
`endif
        for (int i = 0; i < 12; i++) cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, acc);

        // Field unpacking, then async reset with items buffered
        send(64'h4, 32'h0000006f, 1'b0, 1'b0);
        chk("t4_pc", out_pc, 64'h4);
        chk("t4_instr", 64'(out_instr), 64'h6f);
        send({$urandom, $urandom}, $urandom, 1'b0, 1'b0);
        send({$urandom, $urandom}, $urandom, 1'b0, 1'b0);
        #2;
        do_reset();
        idle(2);

        // Random traffic, framing disabled then enabled
        for (int phase = 0; phase < 2; phase++) begin
            tlast_interval = (phase == 0) ? 32'd0 : 32'd3;
            for (int i = 0; i < 400; i++) begin
                en = ($urandom_range(0, 9) != 0);
                clear_errors = (phase == 1) && ($urandom_range(0, 49) == 0);
                cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, acc);
            end
            clear_errors = 1'b0;
            en = 1'b1;
            if (phase == 0) chk("t5_no_ferr", 64'(framing_error), 64'd0);
            idle(12);
        end

`ifdef CMS_RX_DROP_ON_FULL_EN
        clear_errors = 1'b1; idle(1); clear_errors = 1'b0;
        for (int i = 0; i < 12; i++) cycle(1'b1, {$urandom, $urandom}, $urandom, 1'b0, 1'b0, acc);
        chk("t6_drops", 64'(drop_count), 64'd4);
        chk("t6_items", 64'(item_count), 64'd12);
        chk("t6_tready", 64'(S_AXIS_tready), 64'd1);
        idle(10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
